// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the ALU frame receiver.
//   - word / result widths
//   - operator codes carried in the low nibble of an operator word
//   - receiver FSM state encoding
//   - is_arith_op(): true for a well-formed add/sub/mul operator word
package calc_pkg;

  localparam int WORD_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'ha;
  localparam logic [OP_W-1:0] OP_SUB = 4'hb;
  localparam logic [OP_W-1:0] OP_MUL = 4'hc;
  localparam logic [OP_W-1:0] OP_CLR = 4'hd;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_OP = 2'd1,
    WAIT_B  = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // An arithmetic operator word must have a zero upper nibble.
  function automatic logic is_arith_op(input logic [WORD_W-1:0] w);
    return (w[7:4] == 4'h0) &&
           ((w[3:0] == OP_ADD) || (w[3:0] == OP_SUB) || (w[3:0] == OP_MUL));
  endfunction

endpackage

// File: rtl/alu_calc.sv
// alu_calc: purely combinational 16-bit arithmetic on two 8-bit operands.
// Ports:
//   i_a, i_b  operands (unsigned, zero-extended to 16 bits)
//   i_op      operator code (OP_ADD / OP_SUB / OP_MUL); other codes give 0
//   o_result  16-bit result; subtraction wraps in two's complement
module alu_calc
  import calc_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [RES_W-1:0]  o_result
);

  logic [RES_W-1:0] w_a;
  logic [RES_W-1:0] w_b;

  assign w_a = {8'h00, i_a};
  assign w_b = {8'h00, i_b};

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = w_a + w_b;
      OP_SUB:  o_result = w_a - w_b;
      OP_MUL:  o_result = w_a * w_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_frame_receiver.sv
// alu_frame_receiver: collects three-word frames (A, operator, B) from an
// unthrottled word stream, computes the result and holds it until accepted.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   valid, data     one frame word per valid cycle (no backpressure)
//   res_ready       downstream accepts the result when res_valid is high
//   res_valid       res/res_op hold a completed, unaccepted result
//   res, res_op     result of the last complete frame and its operator
//   err             one-cycle pulse: malformed operator word, frame dropped
//   ovf             one-cycle pulse: word dropped while a result was pending
//   busy            state is not WAIT_A
//   dbg_state       current FSM state, for observation only
// Handshake: a result is transferred on a cycle where res_valid and res_ready
// are both high; res_valid then falls on the next cycle. The input side has
// no ready: a word offered while a result is pending is lost and flagged.
module alu_frame_receiver
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [WORD_W-1:0] data,
  input  logic              res_ready,
  output logic              res_valid,
  output logic [RES_W-1:0]  res,
  output logic [OP_W-1:0]   res_op,
  output logic              err,
  output logic              ovf,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_e            r_state;
  state_e            w_next_state;

  logic [WORD_W-1:0] r_a;
  logic [OP_W-1:0]   r_op;
  logic [RES_W-1:0]  r_res;
  logic [OP_W-1:0]   r_res_op;
  logic              r_res_valid;
  logic              r_err;
  logic              r_ovf;
  logic              r_busy;

  logic              w_op_ok;
  logic              w_op_clr;
  logic              w_cap_a;
  logic              w_cap_op;
  logic              w_cap_b;
  logic              w_drop_a;
  logic              w_err_set;
  logic              w_ovf_set;
  logic [RES_W-1:0]  w_alu_res;

  assign w_op_ok  = is_arith_op(data);
  // Clear is recognised on the low nibble alone.
  assign w_op_clr = (data[3:0] == OP_CLR);

  // B is taken straight from the bus so the result registers on the same
  // edge that samples B.
  alu_calc u_alu (
    .i_a      (r_a),
    .i_b      (data),
    .i_op     (r_op),
    .o_result (w_alu_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= WAIT_A;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_A:  if (valid) w_next_state = WAIT_OP;
      WAIT_OP: if (valid) w_next_state = w_op_ok ? WAIT_B : WAIT_A;
      WAIT_B:  if (valid) w_next_state = HOLD;
      HOLD:    if (r_res_valid && res_ready) w_next_state = WAIT_A;
      default: w_next_state = WAIT_A;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_cap_a   = 1'b0;
    w_cap_op  = 1'b0;
    w_cap_b   = 1'b0;
    w_drop_a  = 1'b0;
    w_err_set = 1'b0;
    w_ovf_set = 1'b0;
    case (r_state)
      WAIT_A:  w_cap_a = valid;
      WAIT_OP: begin
        w_cap_op  = valid && w_op_ok;
        w_drop_a  = valid && !w_op_ok;
        w_err_set = valid && !w_op_ok && !w_op_clr;
      end
      WAIT_B:  w_cap_b = valid;
      HOLD:    w_ovf_set = valid;
      default: ;
    endcase
  end

  // Capture and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a         <= '0;
      r_op        <= '0;
      r_res       <= '0;
      r_res_op    <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_cap_a)  r_a  <= data;
      if (w_drop_a) r_a  <= '0;
      if (w_cap_op) r_op <= data[3:0];
      if (w_cap_b) begin
        r_res    <= w_alu_res;
        r_res_op <= r_op;
      end
      r_res_valid <= (w_next_state == HOLD);
      r_err       <= w_err_set;
      r_ovf       <= w_ovf_set;
      r_busy      <= (w_next_state != WAIT_A);
    end
  end

  assign res_valid = r_res_valid;
  assign res       = r_res;
  assign res_op    = r_res_op;
  assign err       = r_err;
  assign ovf       = r_ovf;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: doc/alu_frame_receiver.md
ALU_FRAME_RECEIVER -- requirements
Module: alu_frame_receiver

Interface
REQ-001: The module SHALL have one clock and a synchronous, active-low reset: clk, rst.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004: valid  input  1  one-cycle strobe: data carries one frame word this cycle.
REQ-005: data  input  8  frame word: operand (8-bit unsigned) or operator (code in data[3:0], data[7:4] zero).
REQ-006: res_ready  input  1  downstream accepts res this cycle when res_valid high.
REQ-007: res_valid  output  1  res/res_op hold a completed result.
REQ-008: res  output  16  result of last complete frame.
REQ-009: res_op  output  4  operator code of that frame.
REQ-010: err  output  1  one-cycle pulse: malformed operator word, frame aborted.
REQ-011: ovf  output  1  one-cycle pulse: word dropped because a result was pending.
REQ-012: busy  output  1  high whenever state is not WAIT_A.

Function
REQ-013: A frame SHALL be three valid words in order: operand A, operator, operand B; words arrive without backpressure.
REQ-014: FSM states SHALL be WAIT_A, WAIT_OP, WAIT_B, HOLD.
REQ-015: WAIT_A + valid: capture A = data, go WAIT_OP.
REQ-016: WAIT_OP + valid: data[3:0] = 4'hd (clear) -> discard A, go WAIT_A, no err.
REQ-017: WAIT_OP + valid: data[3:0] in {4'ha add, 4'hb sub, 4'hc mul} and data[7:4] = 0 -> capture op, go WAIT_B.
REQ-018: WAIT_OP + valid: any other word -> err pulses the next cycle, discard frame, go WAIT_A.
REQ-019: WAIT_B + valid: capture B, compute result, go HOLD; res_valid SHALL rise on the cycle after B is sampled (latency 1).
REQ-020: Arithmetic SHALL be 16-bit: add = zext(A)+zext(B); sub = zext(A)-zext(B) two's-complement wrap (3-5 = 16'hFFFE); mul = A*B unsigned (255*255 = 16'hFE01).
REQ-021: res, res_op SHALL be stable while res_valid high and not yet accepted.
REQ-022: HOLD + res_valid & res_ready: res_valid falls next cycle, go WAIT_A.
REQ-023: HOLD + valid (with or without res_ready same cycle): word dropped, ovf pulses next cycle; res_ready handling per REQ-022 is unaffected.
REQ-024: Cycles with valid low SHALL never change state; there is no timeout.
REQ-025: err and ovf SHALL each be high for exactly one cycle per event, never together.
REQ-026: res and res_op SHALL retain their last value after acceptance until the next frame completes.

Reset
REQ-027: rst low at a rising edge SHALL force state WAIT_A, res_valid 0, res 16'h0000, res_op 4'h0, err 0, ovf 0, busy 0, internal A/B/op cleared.
REQ-028: Reset mid-frame or in HOLD SHALL discard the partial frame or pending result; the first valid after rst rises is operand A.
REQ-029: A valid word sampled in the same cycle as rst low SHALL be ignored.

Structure
REQ-030: Shared package calc_pkg SHALL hold operator codes (OP_ADD 4'ha, OP_SUB 4'hb, OP_MUL 4'hc, OP_CLR 4'hd), the FSM state enum, and widths (WORD_W 8, RES_W 16).
REQ-031: Arithmetic SHALL live in one combinational sub-module alu_calc (inputs A, B, op; output 16-bit result); the FSM, capture registers and output registers stay in alu_frame_receiver.
REQ-032: All outputs SHALL be driven directly from registers.

Verification
REQ-033: Words 8'd12, 8'h0a, 8'd30, res_ready high -> res_valid one cycle after B, res 16'd42, res_op 4'ha, then WAIT_A.
REQ-034: Words 8'd3, 8'h0b, 8'd5, res_ready low 4 cycles -> res 16'hFFFE held stable 4 cycles; accepted on res_ready, res_valid drops next cycle.
REQ-035: Words 8'd7, 8'h0d, then 8'd9, 8'h0c, 8'd9 -> no err, single result 16'd81.
REQ-036: Words 8'd1, 8'h1a -> err one-cycle pulse, busy low; next frame 8'd2, 8'h0a, 8'd2 -> res 16'd4.
REQ-037: Frame 8'd255, 8'h0c, 8'd255 held unaccepted, extra word 8'd4 -> ovf pulse, res stays 16'hFE01.
REQ-038: Reset asserted after 8'd5, 8'h0a (in WAIT_B) -> all outputs zero; then 8'd1, 8'h0a, 8'd1 -> res 16'd2.
